// File: rtl/tl_uh_sram_responder.sv
// TileLink-UH slave in front of a single-port on-chip SRAM: Get bursts return AccessAckData,
// PutFull/PutPartial bursts return one AccessAck. One transaction in flight.
//   state | meaning
//   IDLE  | waiting for the first A beat of a request
//   READ  | streaming AccessAckData beats, next SRAM read issued on each D fire
//   WRITE | accepting remaining Put beats and writing them
//   DRAIN | swallowing remaining beats of an illegal Put
//   RESP  | holding the single AccessAck until it is consumed
module tl_uh_sram_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          SIZE_LOG2 = 14,
  parameter int          MAX_SIZE  = 7
) (
  input  logic        cpu_clk_i,
  input  logic        cpu_rst_ni,
  input  logic [2:0]  tl_a_opcode,
  input  logic [2:0]  tl_a_param,
  input  logic [3:0]  tl_a_size,
  input  logic [31:0] tl_a_address,
  input  logic [3:0]  tl_a_mask,
  input  logic [31:0] tl_a_data,
  input  logic        tl_a_corrupt,
  input  logic        tl_a_valid,
  output logic        tl_a_ready,
  output logic [2:0]  tl_d_opcode,
  output logic [1:0]  tl_d_param,
  output logic [3:0]  tl_d_size,
  output logic        tl_d_denied,
  output logic [31:0] tl_d_data,
  output logic        tl_d_corrupt,
  output logic        tl_d_valid,
  input  logic        tl_d_ready
);

  localparam int AW    = SIZE_LOG2 - 2;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [2:0] {IDLE, READ, WRITE, RESP, DRAIN} state_t;

  state_t       state;
  logic         a_ready_q;
  logic         d_valid_q;
  logic [2:0]   d_opcode_q;
  logic [3:0]   d_size_q;
  logic         d_denied_q;
  logic         d_corrupt_q;
  logic         rd_ok_q;
  logic [AW-1:0] cur_word;
  logic [13:0]  beats_left;

  logic [31:0]  mem [0:DEPTH-1];
  logic [31:0]  rd_q;

  logic          a_fire, d_fire;
  logic          a_is_get, a_legal;
  logic [AW-1:0] a_word;
  logic [13:0]   a_beats_m1;
  logic [31:0]   align_mask;
  logic          sram_re, sram_we;
  logic [AW-1:0] sram_addr;
  logic [3:0]    sram_wmask;
  logic          unused_param;

  assign unused_param = ^tl_a_param;

  always_comb begin
    a_fire     = tl_a_valid & a_ready_q;
    d_fire     = d_valid_q & tl_d_ready;
    a_is_get   = (tl_a_opcode == 3'd4);
    a_word     = tl_a_address[SIZE_LOG2-1:2];
    align_mask = (32'd1 << tl_a_size) - 32'd1;
    a_legal    = ((tl_a_opcode == 3'd0) | (tl_a_opcode == 3'd1) | a_is_get)
               & (tl_a_size <= 4'(MAX_SIZE))
               & ((tl_a_address & align_mask) == 32'd0)
               & (tl_a_address[31:SIZE_LOG2] == BASE_ADDR[31:SIZE_LOG2]);
    // Counter holds beats-1 so a 2^13-beat illegal burst still fits.
    a_beats_m1 = (tl_a_size <= 4'd2) ? 14'd0
               : 14'((15'd1 << (tl_a_size - 4'd2)) - 15'd1);

    sram_re    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = cur_word + AW'(1);
    sram_wmask = tl_a_mask;
    case (state)
      IDLE: begin
        sram_addr = a_word;
        if (a_fire) begin
          sram_re = a_is_get & a_legal;
          sram_we = ~a_is_get & a_legal & ~tl_a_corrupt;
        end
      end
      READ:  sram_re = d_fire & (beats_left != 14'd0) & rd_ok_q;
      WRITE: sram_we = a_fire & ~tl_a_corrupt;
      default: ;
    endcase
  end

  // Read data is only refreshed on an issued read, so it holds under backpressure.
  always_ff @(posedge cpu_clk_i) begin
    if (sram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= tl_a_data[8*b +: 8];
      end
    end
    if (sram_re) rd_q <= mem[sram_addr];
  end

  always_ff @(posedge cpu_clk_i or negedge cpu_rst_ni) begin
    if (!cpu_rst_ni) begin
      state       <= IDLE;
      a_ready_q   <= 1'b0;
      d_valid_q   <= 1'b0;
      d_opcode_q  <= 3'd0;
      d_size_q    <= 4'd0;
      d_denied_q  <= 1'b0;
      d_corrupt_q <= 1'b0;
      rd_ok_q     <= 1'b0;
      cur_word    <= '0;
      beats_left  <= 14'd0;
    end else begin
      case (state)
        IDLE: begin
          if (a_fire) begin
            cur_word   <= a_word;
            beats_left <= a_beats_m1;
            d_size_q   <= tl_a_size;
            d_denied_q <= ~a_legal;
            if (a_is_get) begin
              state       <= READ;
              a_ready_q   <= 1'b0;
              d_valid_q   <= 1'b1;
              d_opcode_q  <= 3'd1;
              d_corrupt_q <= ~a_legal;
              rd_ok_q     <= a_legal;
            end else begin
              d_opcode_q  <= 3'd0;
              d_corrupt_q <= 1'b0;
              rd_ok_q     <= 1'b0;
              if (a_beats_m1 == 14'd0) begin
                state     <= RESP;
                a_ready_q <= 1'b0;
                d_valid_q <= 1'b1;
              end else begin
                state     <= a_legal ? WRITE : DRAIN;
                a_ready_q <= 1'b1;
              end
            end
          end else begin
            a_ready_q <= 1'b1;
          end
        end
        READ: begin
          if (d_fire) begin
            if (beats_left == 14'd0) begin
              state     <= IDLE;
              d_valid_q <= 1'b0;
              a_ready_q <= 1'b1;
            end else begin
              beats_left <= beats_left - 14'd1;
              cur_word   <= cur_word + AW'(1);
            end
          end
        end
        WRITE, DRAIN: begin
          if (a_fire) begin
            cur_word   <= cur_word + AW'(1);
            beats_left <= beats_left - 14'd1;
            if (beats_left == 14'd1) begin
              state     <= RESP;
              a_ready_q <= 1'b0;
              d_valid_q <= 1'b1;
            end
          end
        end
        RESP: begin
          if (d_fire) begin
            state     <= IDLE;
            d_valid_q <= 1'b0;
            a_ready_q <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          d_valid_q <= 1'b0;
          a_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign tl_a_ready   = a_ready_q;
  assign tl_d_valid   = d_valid_q;
  assign tl_d_opcode  = d_opcode_q;
  assign tl_d_param   = 2'd0;
  assign tl_d_size    = d_size_q;
  assign tl_d_denied  = d_denied_q;
  assign tl_d_corrupt = d_corrupt_q;
  assign tl_d_data    = (d_valid_q & rd_ok_q) ? rd_q : 32'd0;

endmodule
